// File: rtl/regs_pkg.sv
// Shared constants and debug FSM encoding for the RV32I integer register file.
package regs_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_REG_NUM = 1 << DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_bus_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_bus_t;

    localparam reg_data_bus_t ZERO_WORD = 32'h0;
    localparam reg_addr_bus_t ZERO_REG  = 5'h0;

    typedef enum logic [1:0] {
        DBG_IDLE   = 2'd0,
        DBG_ACCESS = 2'd1,
        DBG_DONE   = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/regs_dbg_ctrl.sv
// Debug access port controller: four-phase handshake, request latching,
// stall against core write-back, and registered ack / read data.
//
//  state      | meaning
//  DBG_IDLE   | waiting for dbg_req_i; latches we/addr/wdata on request
//  DBG_ACCESS | performs the access; writes stall while the core writes back
//  DBG_DONE   | dbg_ack_o high; waits for dbg_req_i to drop
module regs_dbg_ctrl
    import regs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    input  logic              core_wr_i,
    input  logic [DATA_W-1:0] dbg_bypass_rdata_i,
    output logic [ADDR_W-1:0] dbg_raddr_o,
    output logic              dbg_wen_o,
    output logic [ADDR_W-1:0] dbg_waddr_o,
    output logic [DATA_W-1:0] dbg_wdata_o,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    dbg_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DBG_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        dbg_wen_o = 1'b0;
        unique case (state_q)
            DBG_IDLE: begin
                if (dbg_req_i) begin
                    we_d    = dbg_we_i;
                    addr_d  = dbg_addr_i;
                    wdata_d = dbg_wdata_i;
                    state_d = DBG_ACCESS;
                end
            end
            DBG_ACCESS: begin
                if (we_q) begin
                    // Core write-back owns the array this cycle; retry next cycle.
                    if (!core_wr_i) begin
                        dbg_wen_o = (addr_q != '0);
                        state_d   = DBG_DONE;
                    end
                end else begin
                    rdata_d = dbg_bypass_rdata_i;
                    state_d = DBG_DONE;
                end
            end
            DBG_DONE: begin
                if (!dbg_req_i) begin
                    state_d = DBG_IDLE;
                end
            end
            default: state_d = DBG_IDLE;
        endcase
        ack_d = (state_d == DBG_DONE);
    end

    assign dbg_raddr_o = addr_q;
    assign dbg_waddr_o = addr_q;
    assign dbg_wdata_o = wdata_q;
    assign dbg_ack_o   = ack_q;
    assign dbg_rdata_o = rdata_q;

endmodule

// File: rtl/regs.sv
// RV32I integer register file: core write-back, two bypassed read ports,
// and a non-halting debug access port with core write priority.
module regs
    import regs_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_NUM = DEF_REG_NUM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wen_i,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];

    logic              core_wr;
    logic              dbg_wen;
    logic [ADDR_W-1:0] dbg_waddr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [ADDR_W-1:0] dbg_raddr;
    logic [DATA_W-1:0] dbg_bypass_rdata;

    assign core_wr = reg_wen_i && (reg_waddr_i != '0);

    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] stored,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (raddr == '0)
            return '0;
        else if (wen && (waddr == raddr))
            return wdata;
        else
            return stored;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Controller only raises dbg_wen when the core is not writing back.
    always_comb begin
        regs_d = regs_q;
        if (core_wr)
            regs_d[reg_waddr_i] = reg_wdata_i;
        else if (dbg_wen)
            regs_d[dbg_waddr] = dbg_wdata;
        regs_d[0] = '0;
    end

    always_comb begin
        reg1_rdata_o     = bypass_read(reg1_raddr_i, regs_q[reg1_raddr_i],
                                       reg_wen_i, reg_waddr_i, reg_wdata_i);
        reg2_rdata_o     = bypass_read(reg2_raddr_i, regs_q[reg2_raddr_i],
                                       reg_wen_i, reg_waddr_i, reg_wdata_i);
        dbg_bypass_rdata = bypass_read(dbg_raddr, regs_q[dbg_raddr],
                                       reg_wen_i, reg_waddr_i, reg_wdata_i);
    end

    regs_dbg_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dbg_ctrl (
        .clk                (clk),
        .rst_n              (rst_n),
        .dbg_req_i          (dbg_req_i),
        .dbg_we_i           (dbg_we_i),
        .dbg_addr_i         (dbg_addr_i),
        .dbg_wdata_i        (dbg_wdata_i),
        .core_wr_i          (core_wr),
        .dbg_bypass_rdata_i (dbg_bypass_rdata),
        .dbg_raddr_o        (dbg_raddr),
        .dbg_wen_o          (dbg_wen),
        .dbg_waddr_o        (dbg_waddr),
        .dbg_wdata_o        (dbg_wdata),
        .dbg_ack_o          (dbg_ack_o),
        .dbg_rdata_o        (dbg_rdata_o)
    );

endmodule

// File: tb/tb_regs.sv
// Directed-vector bench for the register file and its debug access port.
module tb_regs;

    logic        clk;
    logic        rst_n;
    logic        reg_wen_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
    logic [4:0]  reg1_raddr_i;
    logic [4:0]  reg2_raddr_i;
    logic [31:0] reg1_rdata_o;
    logic [31:0] reg2_rdata_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    regs dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_wen_i    (reg_wen_i),
        .reg_waddr_i  (reg_waddr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg1_raddr_i (reg1_raddr_i),
        .reg2_raddr_i (reg2_raddr_i),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_rdata_o (reg2_rdata_o),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_ack_o    (dbg_ack_o),
        .dbg_rdata_o  (dbg_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [4:0] a1, input logic [4:0] a2);
        reg1_raddr_i = a1;
        reg2_raddr_i = a2;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        reg_wen_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
        reg1_raddr_i = '0; reg2_raddr_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
        #12;
        check_vec("rst_ack", {31'd0, dbg_ack_o}, 32'h0);
        check_vec("rst_rdata", dbg_rdata_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            peek(5'(i), 5'(31 - i));
            check_vec($sformatf("rst_rd1_x%0d", i), reg1_rdata_o, 32'h0);
            check_vec($sformatf("rst_rd2_x%0d", 31 - i), reg2_rdata_o, 32'h0);
        end

        // Core write x5 with same-cycle bypass
        reg_wen_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'h0000_0064;
        peek(5'd5, 5'd6);
        check_vec("bypass_x5", reg1_rdata_o, 32'h64);
        check_vec("bypass_other", reg2_rdata_o, 32'h0);
        tick();
        reg_wen_i = 1'b0;
        peek(5'd5, 5'd5);
        check_vec("stored_x5_p1", reg1_rdata_o, 32'h64);
        check_vec("stored_x5_p2", reg2_rdata_o, 32'h64);

        reg_wen_i = 1'b1; reg_waddr_i = 5'd0; reg_wdata_i = 32'hFFFF_FFFF;
        peek(5'd0, 5'd0);
        check_vec("x0_no_bypass", reg1_rdata_o, 32'h0);
        tick();
        reg_wen_i = 1'b0;
        peek(5'd0, 5'd5);
        check_vec("x0_after_wr", reg1_rdata_o, 32'h0);

        // Debug write x7 stalled three cycles by core write-back to x3
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'hDEAD_BEEF;
        tick();
        dbg_we_i = 1'b0; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h0;
        reg_wen_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'h0000_0333;
        for (int s = 0; s < 3; s++) begin
            tick();
            peek(5'd3, 5'd7);
            check_vec($sformatf("stall%0d_ack", s), {31'd0, dbg_ack_o}, 32'h0);
            check_vec($sformatf("stall%0d_x7", s), reg2_rdata_o, 32'h0);
        end
        reg_wen_i = 1'b0;
        peek(5'd3, 5'd7);
        check_vec("stall_x7_pre", reg2_rdata_o, 32'h0);
        tick();
        check_vec("dwr_ack", {31'd0, dbg_ack_o}, 32'h1);
        check_vec("dwr_x7", reg2_rdata_o, 32'hDEAD_BEEF);
        check_vec("dwr_x3", reg1_rdata_o, 32'h0000_0333);
        check_vec("dwr_rdata_kept", dbg_rdata_o, 32'h0);
        dbg_req_i = 1'b0;
        tick();
        check_vec("dwr_ack_drop", {31'd0, dbg_ack_o}, 32'h0);

        // Debug read x5 with same-cycle core write to x5
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
        tick();
        reg_wen_i = 1'b1; reg_waddr_i = 5'd5; reg_wdata_i = 32'h1234_5678;
        tick();
        reg_wen_i = 1'b0;
        check_vec("drd_bypass", dbg_rdata_o, 32'h1234_5678);
        check_vec("drd_ack", {31'd0, dbg_ack_o}, 32'h1);
        tick();
        check_vec("drd_ack_hold", {31'd0, dbg_ack_o}, 32'h1);
        dbg_req_i = 1'b0;
        tick();
        check_vec("drd_ack_drop", {31'd0, dbg_ack_o}, 32'h0);
        check_vec("drd_rdata_hold", dbg_rdata_o, 32'h1234_5678);

        // Debug read x7, then debug write x0 must not disturb rdata
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd7;
        tick();
        tick();
        check_vec("drd_x7", dbg_rdata_o, 32'hDEAD_BEEF);
        dbg_req_i = 1'b0;
        tick();
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_wdata_i = 32'h1;
        tick();
        tick();
        peek(5'd0, 5'd7);
        check_vec("dwr_x0_ack", {31'd0, dbg_ack_o}, 32'h1);
        check_vec("dwr_x0_val", reg1_rdata_o, 32'h0);
        check_vec("dwr_x0_rdata", dbg_rdata_o, 32'hDEAD_BEEF);
        dbg_req_i = 1'b0;
        tick();
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd0;
        tick();
        tick();
        check_vec("drd_x0", dbg_rdata_o, 32'h0);
        dbg_req_i = 1'b0;
        tick();

        // Request dropped during ACCESS: one-cycle ack pulse
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
        tick();
        dbg_req_i = 1'b0;
        tick();
        check_vec("early_drop_ack", {31'd0, dbg_ack_o}, 32'h1);
        check_vec("early_drop_rd", dbg_rdata_o, 32'h0000_0333);
        tick();
        check_vec("early_drop_ack0", {31'd0, dbg_ack_o}, 32'h0);

        // Reset while a debug write is stalled in ACCESS
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'hAAAA_AAAA;
        tick();
        reg_wen_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'h0000_0999;
        tick();
        #2;
        rst_n = 1'b0;
        reg_wen_i = 1'b0;
        dbg_req_i = 1'b0;
        #1;
        check_vec("mid_rst_ack", {31'd0, dbg_ack_o}, 32'h0);
        check_vec("mid_rst_rdata", dbg_rdata_o, 32'h0);
        peek(5'd3, 5'd5);
        check_vec("mid_rst_x3", reg1_rdata_o, 32'h0);
        check_vec("mid_rst_x5", reg2_rdata_o, 32'h0);
        peek(5'd7, 5'd9);
        check_vec("mid_rst_x7", reg1_rdata_o, 32'h0);
        check_vec("mid_rst_x9", reg2_rdata_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        peek(5'd7, 5'd9);
        check_vec("post_rst_x9", reg2_rdata_o, 32'h0);
        check_vec("post_rst_ack", {31'd0, dbg_ack_o}, 32'h0);

        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h5555_5555;
        tick();
        check_vec("post_rst_access_ack", {31'd0, dbg_ack_o}, 32'h0);
        tick();
        peek(5'd7, 5'd9);
        check_vec("post_rst_dwr_ack", {31'd0, dbg_ack_o}, 32'h1);
        check_vec("post_rst_dwr_x9", reg2_rdata_o, 32'h5555_5555);
        dbg_req_i = 1'b0;
        tick();
        check_vec("post_rst_ack_drop", {31'd0, dbg_ack_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
